segment_bus_decoder: RTL and testbench

- Receiving end of the multiplexed 7-segment bus: monitors the active-low SEGMENT/DIG lines of a 4-digit scanned display and recovers the four displayed characters as ASCII.
- Used as a loopback checker and display-mirror, e.g. feeding range-finder readings back to logic or a UART.
- Applies a per-digit stability filter, detects bus glitches and scan loss, and flags patterns that do not decode to a character.

---
 rtl/segment_bus_decoder.sv | 194 +++++++++++++++++++
 tb/tb_segment_bus_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_bus_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : segment_bus_decoder
//  Purpose  : Receiver for a scanned 4-digit active-low 7-segment bus.
//             Recovers the displayed characters as ASCII, applies a per-digit
//             stability filter, and flags glitches, scan loss and bad patterns.
//  Options  : SEGDEC_INPUT_SYNC_EN - adds a 2-flop input synchronizer
//             (latency +2 cycles)
//  Revision : 1.0 - initial release
// ============================================================================
module segment_bus_decoder #(
  parameter int STABLE_SCANS   = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] segment_i,
  input  logic [3:0] dig_i,
  output logic [7:0] char1_o,
  output logic [7:0] char2_o,
  output logic [7:0] char3_o,
  output logic [7:0] char4_o,
  output logic       update_o,
  output logic       valid_o,
  output logic       bad_char_o,
  output logic       glitch_o
);

  localparam logic [3:0]      C_STABLE  = 4'(STABLE_SCANS);
  localparam logic [TO_W-1:0] C_TIMEOUT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] C_TO_ONE  = TO_W'(1);

  logic [7:0] seg_in;
  logic [3:0] dig_in;

`ifdef SEGDEC_INPUT_SYNC_EN
  logic [7:0] seg_s1_q, seg_s2_q;
  logic [3:0] dig_s1_q, dig_s2_q;

  // Two-flop synchronizer; resets to an all-blank bus
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seg_s1_q <= 8'hFF;
      seg_s2_q <= 8'hFF;
      dig_s1_q <= 4'hF;
      dig_s2_q <= 4'hF;
    end else begin
      seg_s1_q <= segment_i;
      seg_s2_q <= seg_s1_q;
      dig_s1_q <= dig_i;
      dig_s2_q <= dig_s1_q;
    end
  end

  assign seg_in = seg_s2_q;
  assign dig_in = dig_s2_q;
`else
  assign seg_in = segment_i;
  assign dig_in = dig_i;
`endif

  logic [7:0] seg_q;
  logic [3:0] sel_q;

  // Stage 0: register the bus and convert to active-high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seg_q <= 8'h00;
      sel_q <= 4'h0;
    end else begin
      seg_q <= ~seg_in;
      sel_q <= ~dig_in;
    end
  end

  // Pattern to ASCII; bit 8 flags a pattern with no decode
  function automatic logic [8:0] decode_seg(input logic [7:0] p);
    logic [8:0] r;
    r = {1'b0, 8'h3F};
    case (p)
      8'h3F: r[7:0] = "0";   8'h30: r[7:0] = "1";   8'h5B: r[7:0] = "2";
      8'h4F: r[7:0] = "3";   8'h66: r[7:0] = "4";   8'h6D: r[7:0] = "5";
      8'h7D: r[7:0] = "6";   8'h07: r[7:0] = "7";   8'h7F: r[7:0] = "8";
      8'h67: r[7:0] = "9";   8'h77: r[7:0] = "A";   8'h7C: r[7:0] = "B";
      8'h39: r[7:0] = "C";   8'h5E: r[7:0] = "D";   8'h79: r[7:0] = "E";
      8'h71: r[7:0] = "F";   8'h3D: r[7:0] = "G";   8'h34: r[7:0] = "H";
      8'h0E: r[7:0] = "J";   8'h36: r[7:0] = "K";   8'h38: r[7:0] = "L";
      8'h37: r[7:0] = "M";   8'h54: r[7:0] = "N";   8'h5C: r[7:0] = "O";
      8'h7B: r[7:0] = "P";   8'hBF: r[7:0] = "Q";   8'h31: r[7:0] = "R";
      8'h2D: r[7:0] = "S";   8'h78: r[7:0] = "T";   8'h1C: r[7:0] = "U";
      8'h2A: r[7:0] = "V";   8'h3E: r[7:0] = "W";   8'h6E: r[7:0] = "Y";
      8'h1B: r[7:0] = "Z";   8'h86: r[7:0] = "!";   8'h22: r[7:0] = 8'h22;
      8'h20: r[7:0] = 8'h27; 8'h40: r[7:0] = "-";   8'h80: r[7:0] = ".";
      8'h48: r[7:0] = "=";   8'h08: r[7:0] = "_";   8'h00: r[7:0] = 8'h20;
      default: r = {1'b1, 8'h3F};
    endcase
    return r;
  endfunction

  logic [3:0]      prev_q;
  logic [7:0]      cand_q [4];
  logic [3:0]      cnt_q  [4];
  logic [3:0]      flags_q;
  logic [TO_W-1:0] to_q;
  logic [7:0]      char_q [4];
  logic            update_q, valid_q, bad_q, glitch_q;

  logic            onehot, multi, visit, match, commit, timeout_now;
  logic [1:0]      dig_idx;
  logic [3:0]      cnt_cur, cnt_new;
  logic [8:0]      dec;
  logic [3:0]      flags_d;
  logic [TO_W-1:0] to_d;

  // Visit detection: a new visit is a one-hot cycle whose digit differs
  // from the previous cycle's active digit (blank/glitch leave none)
  always_comb begin
    onehot  = (sel_q != 4'h0) && ((sel_q & (sel_q - 4'd1)) == 4'h0);
    multi   = (sel_q != 4'h0) && !onehot;
    visit   = onehot && (sel_q != prev_q);
    dig_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (sel_q[i]) dig_idx = 2'(i);
    end
  end

  // Stability filter, commit decision, timeout and VALID next-state.
  // Reaching the timeout also clears the match counts so a resumed scan
  // re-qualifies every digit from scratch.
  always_comb begin
    cnt_cur     = cnt_q[dig_idx];
    match       = (cand_q[dig_idx] == seg_q);
    cnt_new     = match ? ((cnt_cur >= C_STABLE) ? C_STABLE : cnt_cur + 4'd1) : 4'd1;
    commit      = visit && (cnt_new == C_STABLE) && (!match || (cnt_cur != C_STABLE));
    dec         = decode_seg(seg_q);
    timeout_now = (to_q == C_TIMEOUT);
    flags_d     = timeout_now ? 4'h0 : flags_q;
    if (commit) flags_d[dig_idx] = 1'b1;
    if (visit)            to_d = '0;
    else if (timeout_now) to_d = to_q;
    else                  to_d = to_q + C_TO_ONE;
  end

  // Filter/flag/counter state and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q   <= 4'h0;
      flags_q  <= 4'h0;
      to_q     <= '0;
      update_q <= 1'b0;
      valid_q  <= 1'b0;
      bad_q    <= 1'b0;
      glitch_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cand_q[i] <= 8'h00;
        cnt_q[i]  <= 4'd0;
        char_q[i] <= 8'h20;
      end
    end else begin
      prev_q   <= onehot ? sel_q : 4'h0;
      flags_q  <= flags_d;
      to_q     <= to_d;
      valid_q  <= (&flags_d) && (to_d != C_TIMEOUT);
      glitch_q <= multi;
      update_q <= 1'b0;
      bad_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (visit && (dig_idx == 2'(i))) begin
          cand_q[i] <= seg_q;
          cnt_q[i]  <= cnt_new;
        end else if (timeout_now) begin
          cnt_q[i]  <= 4'd0;
        end
      end
      if (commit) begin
        char_q[dig_idx] <= dec[7:0];
        update_q        <= (dec[7:0] != char_q[dig_idx]);
        bad_q           <= dec[8];
      end
    end
  end

  assign char1_o    = char_q[3];
  assign char2_o    = char_q[2];
  assign char3_o    = char_q[1];
  assign char4_o    = char_q[0];
  assign update_o   = update_q;
  assign valid_o    = valid_q;
  assign bad_char_o = bad_q;
  assign glitch_o   = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_segment_bus_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_segment_bus_decoder
//  Purpose  : Self-checking bench for segment_bus_decoder: directed scans
//             plus randomized bus traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_segment_bus_decoder;

  localparam int S = 2;
  localparam int T = 1024;
`ifdef SEGDEC_INPUT_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] segment_i = 8'hFF;
  logic [3:0] dig_i = 4'hF;
  logic [7:0] char1_o, char2_o, char3_o, char4_o;
  logic       update_o, valid_o, bad_char_o, glitch_o;

  segment_bus_decoder #(.STABLE_SCANS(S), .TIMEOUT_CYCLES(T), .TO_W(11)) dut (
    .clk_i(clk), .rst_i(rst_i), .segment_i(segment_i), .dig_i(dig_i),
    .char1_o(char1_o), .char2_o(char2_o), .char3_o(char3_o), .char4_o(char4_o),
    .update_o(update_o), .valid_o(valid_o), .bad_char_o(bad_char_o),
    .glitch_o(glitch_o)
  );

  always #5 clk = ~clk;

  // ---------------- decode table ----------------
  logic [7:0] pats_t [42] = '{
    8'h3F,8'h30,8'h5B,8'h4F,8'h66,8'h6D,8'h7D,8'h07,8'h7F,8'h67,
    8'h77,8'h7C,8'h39,8'h5E,8'h79,8'h71,8'h3D,8'h34,8'h0E,8'h36,8'h38,8'h37,
    8'h54,8'h5C,8'h7B,8'hBF,8'h31,8'h2D,8'h78,8'h1C,8'h2A,8'h3E,8'h6E,8'h1B,
    8'h86,8'h22,8'h20,8'h40,8'h80,8'h48,8'h08,8'h00};
  string      asc_t = "0123456789ABCDEFGHJKLMNOPQRSTUVWYZ!\"'-.=_ ";
  logic [7:0] dmap  [256];
  bit         dbad  [256];

  // ---------------- behavioural model ----------------
  logic [7:0] pipe_s [D];
  logic [3:0] pipe_d [D];
  int         m_cand [4];
  int         m_cnt  [4];
  bit         m_flag [4];
  logic [7:0] m_char [4];
  int         m_prev, m_to;
  bit         e_upd, e_bad, e_gl, e_val;

  int vectors = 0, miscompares = 0, cyc = 0;
  int upd_cnt = 0, bad_cnt = 0, gl_cnt = 0, first_upd = -1;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cand[i] = 0; m_cnt[i] = 0; m_flag[i] = 0; m_char[i] = 8'h20;
    end
    for (int i = 0; i < D; i++) begin pipe_s[i] = 8'h00; pipe_d[i] = 4'h0; end
    m_prev = -1; m_to = 0; e_upd = 0; e_bad = 0; e_gl = 0; e_val = 0;
  endtask

  // seg/sel are active-high views of the bus as seen by stage 0
  task automatic model_proc(input logic [7:0] seg, input logic [3:0] sel);
    int  n, d, oldc, newc;
    bit  visit, same, commit, timed;
    n = $countones(sel);
    d = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) d = i;
    e_gl = (n > 1); e_upd = 0; e_bad = 0; commit = 0;
    timed = (m_to == T);
    visit = (n == 1) && (d != m_prev);
    if (visit) begin
      oldc = m_cnt[d];
      same = (int'(seg) == m_cand[d]);
      newc = same ? ((oldc + 1 > S) ? S : oldc + 1) : 1;
      commit = (newc == S) && !(same && oldc == S);
      m_cand[d] = int'(seg);
      m_cnt[d]  = newc;
    end
    if (timed) begin
      for (int i = 0; i < 4; i++) begin
        m_flag[i] = 0;
        if (!(visit && i == d)) m_cnt[i] = 0;
      end
    end
    if (commit) begin
      e_upd = (dmap[seg] != m_char[d]);
      e_bad = dbad[seg];
      m_char[d] = dmap[seg];
      m_flag[d] = 1;
    end
    m_to   = visit ? 0 : ((m_to + 1 > T) ? T : m_to + 1);
    m_prev = (n == 1) ? d : -1;
    e_val  = m_flag[0] && m_flag[1] && m_flag[2] && m_flag[3] && (m_to < T);
  endtask

  task automatic model_edge(input logic r, input logic [7:0] segn, input logic [3:0] dign);
    if (r) begin
      model_reset();
    end else begin
      model_proc(pipe_s[D-1], pipe_d[D-1]);
      for (int i = D - 1; i > 0; i--) begin pipe_s[i] = pipe_s[i-1]; pipe_d[i] = pipe_d[i-1]; end
      pipe_s[0] = ~segn; pipe_d[0] = ~dign;
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One clock: drive, advance, update model, compare every output
  task automatic step(input logic r, input logic [7:0] segn, input logic [3:0] dign);
    logic [39:0] act, exp;
    rst_i = r; segment_i = segn; dig_i = dign;
    @(posedge clk); #1;
    model_edge(r, segn, dign);
    act = {char1_o, char2_o, char3_o, char4_o, update_o, valid_o, bad_char_o, glitch_o, 4'h0};
    exp = {m_char[3], m_char[2], m_char[1], m_char[0], e_upd, e_val, e_bad, e_gl, 4'h0};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL outputs cycle %0d: got %h, required %h", cyc, act, exp);
    end
    if (update_o === 1'b1) begin
      upd_cnt++;
      if (first_upd < 0) first_upd = cyc + 1;
    end
    if (bad_char_o === 1'b1) bad_cnt++;
    if (glitch_o === 1'b1)   gl_cnt++;
    cyc++;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'hFF, 4'hF);
  endtask

  // One full scan; p3 is shown on DIG[3] (CHAR1) ... p0 on DIG[0] (CHAR4)
  task automatic scan(input logic [7:0] p3, p2, p1, p0, input int len);
    logic [7:0] p [4];
    p[3] = p3; p[2] = p2; p[1] = p1; p[0] = p0;
    for (int k = 3; k >= 0; k--)
      for (int j = 0; j < len; j++) step(1'b0, ~p[k], ~(4'b0001 << k));
  endtask

  task automatic do_reset();
    step(1'b1, 8'hFF, 4'hF);
    step(1'b1, 8'hFF, 4'hF);
  endtask

  int e, u0, g0, b0;
  logic [7:0] rp [4];
  logic [7:0] pool [12] = '{8'h3F,8'h30,8'h5B,8'h4F,8'h66,8'h77,8'h00,8'h55,
                            8'h36,8'h80,8'hFF,8'h12};

  initial begin
    for (int i = 0; i < 256; i++) begin dmap[i] = 8'h3F; dbad[i] = 1; end
    for (int j = 0; j < 42; j++) begin dmap[pats_t[j]] = asc_t[j]; dbad[pats_t[j]] = 0; end
    model_reset();

    // Reset state
    do_reset();
    lit("reset_char1", int'(char1_o), 8'h20);
    lit("reset_valid", int'(valid_o), 0);

    // "1234" acquisition, latency of first UPDATE
    upd_cnt = 0; first_upd = -1;
    scan(8'h30, 8'h5B, 8'h4F, 8'h66, 4);
    e = cyc;
    scan(8'h30, 8'h5B, 8'h4F, 8'h66, 4);
    blank(D + 2);
    lit("scan_char1", int'(char1_o), 8'h31);
    lit("scan_char2", int'(char2_o), 8'h32);
    lit("scan_char3", int'(char3_o), 8'h33);
    lit("scan_char4", int'(char4_o), 8'h34);
    lit("scan_valid", int'(valid_o), 1);
    lit("scan_updates", upd_cnt, 4);
    lit("update_latency", first_upd, e + D + 1);

    // Glitch mid-scan
    u0 = upd_cnt; g0 = gl_cnt;
    step(1'b0, ~8'h30, 4'b0111);
    step(1'b0, ~8'h30, 4'b0011);
    scan(8'h30, 8'h5B, 8'h4F, 8'h66, 3);
    scan(8'h30, 8'h5B, 8'h4F, 8'h66, 3);
    blank(D + 2);
    lit("glitch_pulses", gl_cnt - g0, 1);
    lit("glitch_no_update", upd_cnt - u0, 0);

    // Undecodable pattern on DIG[1]
    b0 = bad_cnt;
    for (int i = 0; i < 3; i++) scan(8'h30, 8'h5B, 8'h55, 8'h66, 2);
    blank(D + 2);
    lit("bad_char3", int'(char3_o), 8'h3F);
    lit("bad_pulses", bad_cnt - b0, 1);

    // Scan loss and recovery
    for (int i = 0; i < 2; i++) scan(8'h30, 8'h5B, 8'h4F, 8'h66, 2);
    blank(D + 2);
    lit("pre_timeout_valid", int'(valid_o), 1);
    blank(T + 4);
    lit("timeout_valid", int'(valid_o), 0);
    lit("timeout_char1", int'(char1_o), 8'h31);
    scan(8'h30, 8'h5B, 8'h4F, 8'h66, 2);
    blank(D + 2);
    lit("resume1_valid", int'(valid_o), 0);
    scan(8'h30, 8'h5B, 8'h4F, 8'h66, 2);
    blank(D + 2);
    lit("resume2_valid", int'(valid_o), 1);

    // Reset mid-scan discards partial counts
    step(1'b0, ~8'h30, 4'b0111);
    step(1'b1, ~8'h30, 4'b0111);
    lit("rst_char2", int'(char2_o), 8'h20);
    lit("rst_valid", int'(valid_o), 0);
    scan(8'h30, 8'h5B, 8'h4F, 8'h66, 2);
    blank(D + 2);
    lit("reacq1_char1", int'(char1_o), 8'h20);
    scan(8'h30, 8'h5B, 8'h4F, 8'h66, 2);
    blank(D + 2);
    lit("reacq2_char1", int'(char1_o), 8'h31);

    // Digit 0 never stable
    do_reset();
    for (int i = 0; i < 6; i++) scan(8'h30, 8'h5B, 8'h4F, (i % 2) ? 8'h7F : 8'h3F, 2);
    blank(D + 2);
    lit("unstable_char4", int'(char4_o), 8'h20);
    lit("unstable_valid", int'(valid_o), 0);

    // Randomized bus traffic
    for (int i = 0; i < 4; i++) rp[i] = pool[$urandom_range(0, 11)];
    begin
      int k, r, len;
      logic [3:0] gd;
      k = 3;
      for (int v = 0; v < 1500; v++) begin
        r = $urandom_range(0, 99);
        if (r < 2) begin
          step(1'b1, 8'hFF, 4'hF);
        end else if (r < 8) begin
          gd = 4'($urandom);
          if ($countones(~gd) < 2) gd = 4'b0000;
          step(1'b0, 8'($urandom), gd);
        end else if (r < 16) begin
          blank($urandom_range(1, 3));
        end else begin
          k = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : (k + 3) % 4;
          if ($urandom_range(0, 9) == 0)
            rp[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) step(1'b0, ~rp[k], ~(4'b0001 << k));
        end
      end
    end
    blank(D + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
